// File: rtl/frequency_encoder.sv
// Pulse-position encoder: a byte D becomes a sync pulse followed by a data pulse
// D+2 enabled cycles later, then a guard interval before the next frame.
module frequency_encoder #(
   parameter int unsigned GUARD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [7:0] data_input,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       pulse_output,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StGap,
      StData,
      StGuard
   } state_e;

   localparam logic [3:0] GuardLoad = 4'(GUARD_CYCLES - 1);

   state_e     state_q, state_d;
   logic [7:0] gap_q, gap_d;
   logic [3:0] guard_q, guard_d;
   logic       pulse_q, pulse_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      guard_d = guard_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (data_valid && enable) begin
               state_d = StSync;
               gap_d   = data_input;
            end
         end
         StSync: begin
            state_d = StGap;
         end
         StGap: begin
            // Counter only moves on timebase ticks; exit needs a tick at zero.
            if (enable) begin
               if (gap_q == 8'd0) begin
                  state_d = StData;
               end else begin
                  gap_d = gap_q - 8'd1;
               end
            end
         end
         StData: begin
            state_d = StGuard;
            guard_d = GuardLoad;
         end
         StGuard: begin
            if (enable) begin
               if (guard_q == 4'd0) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  guard_d = guard_q - 4'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are precomputed from the next state so they leave flops.
      pulse_d = (state_d == StSync) || (state_d == StData);
      busy_d  = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         gap_q   <= 8'd0;
         guard_q <= 4'd0;
         pulse_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         guard_q <= guard_d;
         pulse_q <= pulse_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign data_ready   = (state_q == StIdle);
   assign pulse_output = pulse_q;
   assign busy         = busy_q;
   assign frame_done   = done_q;

endmodule
